// File: rtl/axi_wr_slave.sv
// rtl/axi_wr_slave.sv - single-outstanding AXI write slave driving a word-wide memory port
//
// Accepts one AW burst at a time, turns each accepted W beat into a one-cycle
// memory write at the current beat address, and returns a single B response.
// Bursts that are illegal for this slave, and beats with a foreign ID, are
// reported as SLVERR without being written.
//
// Ports:
//   clk, reset                  sole clock (rising edge); synchronous active-high reset
//   aw* (valid/ready/id/addr/len/size/burst)   write-address channel
//   w*  (valid/ready/id/data/strb/last)        write-data channel
//   b*  (valid/ready/id/resp)                  write-response channel
//   mem_we, mem_addr, mem_wdata, mem_wstrb     memory write port, word addressed
module axi_wr_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter int MEM_AW = 10
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [LEN_W-1:0]    awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,

  input  logic                wvalid,
  output logic                wready,
  input  logic [ID_W-1:0]     wid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,

  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,

  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int SIZE_MAX = $clog2(STRB_W);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  // bad_q: whole burst is illegal, so every beat is dropped.
  // err_q: something went wrong somewhere; only affects bresp.
  logic                bad_q, bad_d;
  logic                err_q, err_d;

  logic                aw_fire;
  logic                w_fire;
  logic                aw_bad;
  logic                at_len;
  logic                wid_ok;
  logic [ADDR_W-1:0]   step;
  logic [ADDR_W-1:0]   wrap_mask;
  logic [ADDR_W-1:0]   addr_next;

  // Handshake readies are also held low while reset is asserted so nothing
  // is accepted or written during the reset cycle itself.
  assign awready = (state_q == IDLE) && !reset;
  assign wready  = (state_q == DATA) && !reset;
  assign bvalid  = (state_q == RESP);
  assign bid     = id_q;
  assign bresp   = (bvalid && err_q) ? 2'b10 : 2'b00;

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign wid_ok  = (wid == id_q);
  assign at_len  = (count_q == len_q);

  assign mem_we    = w_fire && !bad_q && wid_ok;
  assign mem_addr  = MEM_AW'(addr_q >> SIZE_MAX);
  assign mem_wdata = wdata;
  assign mem_wstrb = wstrb;

  // Legality of the incoming burst, evaluated on the raw AW fields.
  always_comb begin
    aw_bad = 1'b0;
    if (awsize > 3'(SIZE_MAX)) begin
      aw_bad = 1'b1;
    end
    if (awburst == BURST_RSVD) begin
      aw_bad = 1'b1;
    end
    if (awburst == BURST_WRAP) begin
      if (!((32'(awlen) == 32'd1) || (32'(awlen) == 32'd3) ||
            (32'(awlen) == 32'd7) || (32'(awlen) == 32'd15))) begin
        aw_bad = 1'b1;
      end
      if ((awaddr & ((ADDR_W'(1) << awsize) - ADDR_W'(1))) != '0) begin
        aw_bad = 1'b1;
      end
    end
  end

  // Next beat address. For WRAP the window is (len+1)<<size bytes; the bits
  // above the window are frozen and only the in-window offset increments.
  always_comb begin
    step      = ADDR_W'(1) << size_q;
    wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    case (burst_q)
      BURST_FIXED: addr_next = addr_q;
      BURST_WRAP:  addr_next = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default:     addr_next = addr_q + step;
    endcase
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    count_d = count_q;
    size_d  = size_q;
    burst_d = burst_q;
    bad_d   = bad_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (aw_fire) begin
          id_d    = awid;
          addr_d  = awaddr;
          len_d   = awlen;
          size_d  = awsize;
          burst_d = awburst;
          count_d = '0;
          bad_d   = aw_bad;
          err_d   = aw_bad;
          state_d = DATA;
        end
      end

      DATA: begin
        if (w_fire) begin
          addr_d = addr_next;
          if (!wid_ok) begin
            err_d = 1'b1;
          end
          // wlast must coincide exactly with the final counted beat.
          if (wlast != at_len) begin
            err_d = 1'b1;
          end
          if (at_len || wlast) begin
            state_d = RESP;
          end else begin
            count_d = count_q + LEN_W'(1);
          end
        end
      end

      RESP: begin
        if (bready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      size_q  <= '0;
      burst_q <= '0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      count_q <= count_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/axi_wr_slave.md
AXI_WR_SLAVE -- requirements
Module: axi_wr_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning W data width in bits (32, 64 or 128).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning AW byte-address width.
REQ-003 SHALL have parameter ID_W, default 4, meaning width of awid/wid/bid.
REQ-004 SHALL have parameter LEN_W, default 4, meaning awlen width (beats = awlen+1).
REQ-005 SHALL have parameter MEM_AW, default 10, meaning word-address width of the memory port.
REQ-006 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port awvalid  in  1  write-address valid.
REQ-009 SHALL have port awready  out  1  write-address ready.
REQ-010 SHALL have port awid  in  ID_W  burst ID.
REQ-011 SHALL have port awaddr  in  ADDR_W  start byte address.
REQ-012 SHALL have port awlen  in  LEN_W  beats minus one.
REQ-013 SHALL have port awsize  in  3  log2 bytes per beat.
REQ-014 SHALL have port awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-015 SHALL have port wvalid  in  1  write-data valid.
REQ-016 SHALL have port wready  out  1  write-data ready.
REQ-017 SHALL have port wid  in  ID_W  data-beat ID.
REQ-018 SHALL have port wdata  in  DATA_W  beat data.
REQ-019 SHALL have port wstrb  in  DATA_W/8  byte strobes.
REQ-020 SHALL have port wlast  in  1  final-beat marker.
REQ-021 SHALL have port bvalid  out  1  response valid.
REQ-022 SHALL have port bready  in  1  response ready.
REQ-023 SHALL have port bid  out  ID_W  response ID (latched awid).
REQ-024 SHALL have port bresp  out  2  00 OKAY, 10 SLVERR.
REQ-025 SHALL have port mem_we  out  1  memory write enable, one cycle per accepted beat.
REQ-026 SHALL have port mem_addr  out  MEM_AW  word address = current byte address >> log2(DATA_W/8), truncated.
REQ-027 SHALL have ports mem_wdata  out  DATA_W and mem_wstrb  out  DATA_W/8, which equal wdata/wstrb of the accepted beat.

Function
REQ-028 SHALL implement FSM states IDLE, DATA and RESP, with one burst outstanding.
REQ-029 SHALL, in IDLE, drive awready=1; on awvalid&&awready it SHALL latch id/addr/len/size/burst, clear the beat counter and error flag, and enter DATA on the next cycle.
REQ-030 SHALL, in DATA, drive wready=1 and awready=0; each wvalid&&wready is one accepted beat.
REQ-031 SHALL drive mem_we combinationally as wvalid&&wready&&!suppress in the same cycle as acceptance, with mem_addr taken from the current beat address.
REQ-032 SHALL advance the beat address after each accepted beat: FIXED holds it; INCR adds 1<<size modulo 2^ADDR_W; WRAP adds 1<<size within an aligned window of (len+1)<<size bytes, returning to the window base at the upper boundary.
REQ-033 SHALL flag a burst error when awsize exceeds log2(DATA_W/8), when awburst=11, or, for WRAP, when len is not in {1,3,7,15} or awaddr is not aligned to 1<<size; a burst error SHALL suppress every mem_we of that burst.
REQ-034 SHALL, on a beat whose wid differs from the latched id, suppress that beat's mem_we and set the error flag.
REQ-035 SHALL end the burst on the beat where count==len, or earlier on any beat with wlast=1; wlast=1 before count==len, or wlast=0 at count==len, SHALL set the error flag.
REQ-036 SHALL enter RESP on the cycle after the terminating beat, with bvalid=1, bid=latched id, and bresp=10 if the error flag is set, else 00.
REQ-037 SHALL hold bvalid/bid/bresp stable until bready; on bvalid&&bready it SHALL return to IDLE, giving awready=1 on the next cycle.
REQ-038 SHALL keep wready=0 outside DATA and bvalid=0 outside RESP.

Reset
REQ-039 SHALL, while reset=1 at a clock edge, enter IDLE with awready=0, wready=0, bvalid=0, bid=0, bresp=00, mem_we=0, and all latched fields cleared; awready SHALL rise on the first cycle after reset deasserts.
REQ-040 SHALL, on reset mid-burst or during RESP, abandon the burst with no B response and no further mem_we.

Verification
REQ-041 Bench SHALL drive INCR awaddr=0x100, len=3, size=2 with four beats and wlast on the 4th -> mem_addr 0x40,0x41,0x42,0x43, then bvalid the cycle after the 4th beat with bresp=00 and bid=awid.
REQ-042 Bench SHALL drive WRAP awaddr=0x108, len=3, size=2 -> byte addresses 0x108,0x10C,0x100,0x104 (mem_addr 0x42,0x43,0x40,0x41) and bresp=00.
REQ-043 Bench SHALL drive FIXED awaddr=0x20, len=2 with 3 beats -> mem_addr=0x08 on all three beats; then WRAP len=2 -> no mem_we and bresp=10.
REQ-044 Bench SHALL drive awid=5 with the 2nd beat wid=6 -> beat 2 write suppressed, beats 1 and 3 written, bresp=10, bid=5.
REQ-045 Bench SHALL drive len=3 with wlast on beat 2 -> burst ends after 2 writes, bresp=10; then hold bready=0 for 5 cycles -> bvalid/bresp stable and awready=0 throughout.
REQ-046 Bench SHALL assert reset after beat 1 of a len=7 burst -> no bvalid, no further mem_we, and awready=1 on the first cycle after reset deasserts.
